clk_en_scheduler: RTL and testbench

Multi-channel rate scheduler that replaces per-consumer derived clocks with single-cycle enable strobes generated from the one system clock. Each channel has a divide ratio, a start/stop control, and a toggle output with 50% duty cycle. All three are programmed through a valid/ready configuration port. Rate changes take effect only at a period boundary, so no runt periods occur. The block sits between the control/CSR logic and the slow-rate consumers: sampling timers, LED/UART-rate logic, and similar.

---
 rtl/clk_en_scheduler.sv | 154 +++++++++++++++
 tb/tb_clk_en_scheduler.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_scheduler.sv
// clk_en_scheduler: multi-channel rate scheduler producing single-cycle enable
// strobes and 50% duty toggle outputs from one system clock.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   cfg_valid     configuration request
//   cfg_ready     addressed channel can accept a request (combinational)
//   cfg_ch        target channel; channels >= N_CH accept and drop the write
//   cfg_div       new divide ratio (0 behaves as 1)
//   cfg_en        1 = run after the update, 0 = stop
//   sync_restart  single-cycle pulse, phase-aligns all running channels
//   tick          per-channel one-cycle enable strobe
//   clk_div       per-channel toggle output, period 2*div cycles
//   busy          per-channel update pending
module clk_en_scheduler #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 10000,
    localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_en,
    input  logic             sync_restart,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  clk_div,
    output logic [N_CH-1:0]  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } ch_state_e;

    // One bit per channel: cfg_ch addresses this channel and it is pending.
    logic [N_CH-1:0] hold_c;

    // Unaddressed (out-of-range) channels never hold, so such writes are dropped.
    assign cfg_ready = ~|hold_c;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        ch_state_e        state_q, state_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] div_q, div_d;
        logic [DIV_W-1:0] sh_div_q, sh_div_d;
        logic             sh_en_q, sh_en_d;
        logic             clk_div_q, clk_div_d;
        logic [DIV_W-1:0] div_eff_c;
        logic             sel_c;
        logic             tick_c;
        logic             xfer_c;

        // Ratio 0 is treated as 1 so the counter always has a valid terminal value.
        assign div_eff_c = (div_q == '0) ? DIV_W'(1) : div_q;
        assign tick_c    = (state_q != ST_IDLE) && (cnt_q == div_eff_c - DIV_W'(1));
        assign sel_c     = (cfg_ch == CH_W'(g));
        assign xfer_c    = cfg_valid && cfg_ready && sel_c;
        assign hold_c[g] = sel_c && (state_q == ST_PEND);

        // Channel state register.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                div_q     <= DIV_W'(DEFAULT_DIV);
                sh_div_q  <= '0;
                sh_en_q   <= 1'b0;
                clk_div_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                div_q     <= div_d;
                sh_div_q  <= sh_div_d;
                sh_en_q   <= sh_en_d;
                clk_div_q <= clk_div_d;
            end
        end

        // Next-state: count, capture shadow config, apply it on the period boundary.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            div_d     = div_q;
            sh_div_d  = sh_div_q;
            sh_en_d   = sh_en_q;
            clk_div_d = clk_div_q;

            case (state_q)
                ST_IDLE: begin
                    if (xfer_c) begin
                        div_d = cfg_div;
                        if (cfg_en) begin
                            state_d   = ST_RUN;
                            cnt_d     = '0;
                            clk_div_d = 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (tick_c) begin
                        cnt_d     = '0;
                        clk_div_d = ~clk_div_q;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                    // A write during the tick cycle waits for the next boundary.
                    if (xfer_c) begin
                        sh_div_d = cfg_div;
                        sh_en_d  = cfg_en;
                        state_d  = ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (tick_c) begin
                        cnt_d     = '0;
                        clk_div_d = ~clk_div_q;
                        div_d     = sh_div_q;
                        state_d   = sh_en_q ? ST_RUN : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Restart realigns active channels; a coincident write lands directly.
            if (sync_restart && (state_q != ST_IDLE)) begin
                cnt_d     = '0;
                clk_div_d = 1'b0;
                if (state_q == ST_PEND) begin
                    div_d   = sh_div_q;
                    state_d = sh_en_q ? ST_RUN : ST_IDLE;
                end
                if (xfer_c) begin
                    div_d   = cfg_div;
                    state_d = cfg_en ? ST_RUN : ST_IDLE;
                end
            end
        end

        assign tick[g]    = tick_c;
        assign clk_div[g] = clk_div_q;
        assign busy[g]    = (state_q == ST_PEND);
    end

endmodule

// File: tb/tb_clk_en_scheduler.sv
// Testbench for clk_en_scheduler: expected tick events are queued per scenario
// (encoded as cycle*4+channel) and popped as the DUT strobes.
module tb_clk_en_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_ch = 2'd0;
    logic [15:0] cfg_div = 16'd0;
    logic        cfg_en = 1'b0;
    logic        sync_restart = 1'b0;
    logic [3:0]  tick;
    logic [3:0]  clk_div;
    logic [3:0]  busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    logic [3:0] emap [0:63];

    clk_en_scheduler #(
        .N_CH        (4),
        .DIV_W       (16),
        .DEFAULT_DIV (10000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .cfg_en       (cfg_en),
        .sync_restart (sync_restart),
        .tick         (tick),
        .clk_div      (clk_div),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        cfg_valid    = 1'b0;
        cfg_ch       = 2'd0;
        cfg_div      = 16'd0;
        cfg_en       = 1'b0;
        sync_restart = 1'b0;
    endtask

    task automatic drive_cfg(input int ch, input int div, input bit en);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = 16'(div);
        cfg_en    = en;
    endtask

    task automatic reset_dut();
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic clear_map();
        for (int r = 0; r < 64; r++) emap[6'(r)] = 4'b0000;
    endtask

    task automatic load_scoreboard(input int last);
        exp_q.delete();
        for (int r = 0; r <= last; r++)
            for (int c = 0; c < 4; c++)
                if (emap[6'(r)][2'(c)]) exp_q.push_back(r * 4 + c);
    endtask

    task automatic test_reset();
        drive_idle();
        #3;
        n_checks++;
        if (tick !== 4'b0000) begin n_fail++; $display("FAIL reset_tick: got %b want 0000", tick); end
        n_checks++;
        if (clk_div !== 4'b0000) begin n_fail++; $display("FAIL reset_clk_div: got %b want 0000", clk_div); end
        n_checks++;
        if (busy !== 4'b0000) begin n_fail++; $display("FAIL reset_busy: got %b want 0000", busy); end
        for (int c = 0; c < 4; c++) begin
            cfg_ch = 2'(c);
            #1;
            n_checks++;
            if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: ch%0d got %b want 1", c, cfg_ready); end
        end
        cfg_ch = 2'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({tick, clk_div, busy} !== 12'h000) begin
            n_fail++; $display("FAIL post_release: tick/clk_div/busy got %h want 000", {tick, clk_div, busy});
        end
    endtask

    task automatic test_start();
        int got;
        logic exp_c;
        reset_dut();
        clear_map();
        for (int k = 1; k <= 4; k++) emap[6'(4 * k)][0] = 1'b1;
        load_scoreboard(17);
        for (int rel = 0; rel <= 17; rel++) begin
            if (rel != 0) @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (tick[2'(c)]) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++; $display("FAIL start_tick: ch%0d ticked in cycle %0d, none expected", c, rel);
                    end else begin
                        got = exp_q.pop_front();
                        if (got != rel * 4 + c) begin
                            n_fail++; $display("FAIL start_tick: ch%0d in cycle %0d, expected ch%0d in cycle %0d", c, rel, got % 4, got / 4);
                        end
                    end
                end
            end
            if (rel >= 1) begin
                exp_c = 1'(((rel - 1) / 4) % 2);
                n_checks++;
                if (clk_div !== {3'b000, exp_c}) begin
                    n_fail++; $display("FAIL start_clk_div: cycle %0d got %b want %b", rel, clk_div, {3'b000, exp_c});
                end
            end
            drive_idle();
            if (rel == 0) begin
                drive_cfg(0, 4, 1'b1);
                #1;
                n_checks++;
                if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL start_ready: got %b want 1", cfg_ready); end
            end
        end
        drive_idle();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL start_missing: %0d ticks not seen, want 0", exp_q.size()); end
    endtask

    task automatic test_rate_change();
        int got;
        int last_t;
        logic exp_b;
        reset_dut();
        clear_map();
        emap[10][1] = 1'b1;
        emap[20][1] = 1'b1;
        emap[23][1] = 1'b1;
        emap[26][1] = 1'b1;
        emap[29][1] = 1'b1;
        load_scoreboard(30);
        last_t = -1;
        for (int rel = 0; rel <= 30; rel++) begin
            if (rel != 0) @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (tick[2'(c)]) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++; $display("FAIL rate_tick: ch%0d ticked in cycle %0d, none expected", c, rel);
                    end else begin
                        got = exp_q.pop_front();
                        if (got != rel * 4 + c) begin
                            n_fail++; $display("FAIL rate_tick: ch%0d in cycle %0d, expected ch%0d in cycle %0d", c, rel, got % 4, got / 4);
                        end
                    end
                end
            end
            if (tick[1]) begin
                if (last_t >= 0) begin
                    n_checks++;
                    if (rel - last_t < 3 || rel - last_t > 10) begin
                        n_fail++; $display("FAIL rate_spacing: got %0d cycles want 3..10", rel - last_t);
                    end
                end
                last_t = rel;
            end
            exp_b = (rel >= 13 && rel <= 20);
            n_checks++;
            if (busy !== {2'b00, exp_b, 1'b0}) begin
                n_fail++; $display("FAIL rate_busy: cycle %0d got %b want %b", rel, busy, {2'b00, exp_b, 1'b0});
            end
            drive_idle();
            cfg_ch = 2'd1;
            if (rel == 0) drive_cfg(1, 10, 1'b1);
            if (rel == 12) drive_cfg(1, 3, 1'b1);
            #1;
            n_checks++;
            if (cfg_ready !== ~exp_b) begin
                n_fail++; $display("FAIL rate_ready: cycle %0d got %b want %b", rel, cfg_ready, ~exp_b);
            end
        end
        drive_idle();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rate_missing: %0d ticks not seen, want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int got;
        int acc_rel;
        logic exp_b;
        reset_dut();
        clear_map();
        emap[6][2]  = 1'b1;
        emap[8][2]  = 1'b1;
        emap[13][2] = 1'b1;
        emap[18][2] = 1'b1;
        for (int r = 7; r <= 19; r += 3) emap[6'(r)][3] = 1'b1;
        load_scoreboard(19);
        acc_rel = -1;
        for (int rel = 0; rel <= 19; rel++) begin
            if (rel != 0) @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (tick[2'(c)]) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++; $display("FAIL b2b_tick: ch%0d ticked in cycle %0d, none expected", c, rel);
                    end else begin
                        got = exp_q.pop_front();
                        if (got != rel * 4 + c) begin
                            n_fail++; $display("FAIL b2b_tick: ch%0d in cycle %0d, expected ch%0d in cycle %0d", c, rel, got % 4, got / 4);
                        end
                    end
                end
            end
            exp_b = ((rel >= 3 && rel <= 6) || rel == 8);
            n_checks++;
            if (busy !== {1'b0, exp_b, 2'b00}) begin
                n_fail++; $display("FAIL b2b_busy: cycle %0d got %b want %b", rel, busy, {1'b0, exp_b, 2'b00});
            end
            drive_idle();
            case (rel)
                0: drive_cfg(2, 6, 1'b1);
                2: begin
                    drive_cfg(2, 2, 1'b1);
                    #1;
                    n_checks++;
                    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ready: got %b want 1", cfg_ready); end
                end
                3: begin
                    drive_cfg(2, 5, 1'b1);
                    #1;
                    n_checks++;
                    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_held_off: got %b want 0", cfg_ready); end
                end
                4: begin
                    drive_cfg(3, 3, 1'b1);
                    #1;
                    n_checks++;
                    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_other_ch: got %b want 1", cfg_ready); end
                end
                default: begin
                    if (rel >= 5 && acc_rel < 0) begin
                        drive_cfg(2, 5, 1'b1);
                        #1;
                        if (cfg_ready === 1'b1) acc_rel = rel;
                    end
                end
            endcase
        end
        drive_idle();
        n_checks++;
        if (acc_rel != 7) begin n_fail++; $display("FAIL b2b_accept_cycle: got %0d want 7", acc_rel); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing: %0d ticks not seen, want 0", exp_q.size()); end
    endtask

    task automatic test_sync_restart();
        int got;
        reset_dut();
        clear_map();
        for (int r = 5; r <= 40; r += 5) emap[6'(r)][0] = 1'b1;
        for (int r = 5; r <= 29; r += 4) emap[6'(r)][1] = 1'b1;
        for (int r = 32; r <= 40; r += 2) emap[6'(r)][1] = 1'b1;
        for (int r = 10; r <= 26; r += 8) emap[6'(r)][2] = 1'b1;
        emap[37][2] = 1'b1;
        for (int r = 12; r <= 30; r += 9) emap[6'(r)][3] = 1'b1;
        emap[39][3] = 1'b1;
        load_scoreboard(40);
        for (int rel = 0; rel <= 40; rel++) begin
            if (rel != 0) @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (tick[2'(c)]) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++; $display("FAIL sync_tick: ch%0d ticked in cycle %0d, none expected", c, rel);
                    end else begin
                        got = exp_q.pop_front();
                        if (got != rel * 4 + c) begin
                            n_fail++; $display("FAIL sync_tick: ch%0d in cycle %0d, expected ch%0d in cycle %0d", c, rel, got % 4, got / 4);
                        end
                    end
                end
            end
            if (rel == 30) begin
                n_checks++;
                if (clk_div !== 4'b0111) begin n_fail++; $display("FAIL sync_pre_clk_div: got %b want 0111", clk_div); end
                n_checks++;
                if (busy !== 4'b0100) begin n_fail++; $display("FAIL sync_pre_busy: got %b want 0100", busy); end
            end
            if (rel == 31) begin
                n_checks++;
                if (clk_div !== 4'b0000) begin n_fail++; $display("FAIL sync_clk_div: got %b want 0000", clk_div); end
                n_checks++;
                if (busy !== 4'b0000) begin n_fail++; $display("FAIL sync_busy: got %b want 0000", busy); end
            end
            drive_idle();
            case (rel)
                0: drive_cfg(0, 5, 1'b1);
                1: drive_cfg(1, 4, 1'b1);
                2: drive_cfg(2, 8, 1'b1);
                3: drive_cfg(3, 9, 1'b1);
                29: drive_cfg(2, 7, 1'b1);
                30: begin
                    sync_restart = 1'b1;
                    drive_cfg(1, 2, 1'b1);
                    #1;
                    n_checks++;
                    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL sync_cfg_ready: got %b want 1", cfg_ready); end
                end
                default: ;
            endcase
        end
        drive_idle();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL sync_missing: %0d ticks not seen, want 0", exp_q.size()); end
    endtask

    task automatic test_div_edge();
        int got;
        logic e0;
        logic e1;
        reset_dut();
        clear_map();
        for (int r = 1; r <= 7; r++)  emap[6'(r)][0] = 1'b1;
        for (int r = 2; r <= 10; r++) emap[6'(r)][1] = 1'b1;
        load_scoreboard(14);
        for (int rel = 0; rel <= 14; rel++) begin
            if (rel != 0) @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (tick[2'(c)]) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++; $display("FAIL div_edge_tick: ch%0d ticked in cycle %0d, none expected", c, rel);
                    end else begin
                        got = exp_q.pop_front();
                        if (got != rel * 4 + c) begin
                            n_fail++; $display("FAIL div_edge_tick: ch%0d in cycle %0d, expected ch%0d in cycle %0d", c, rel, got % 4, got / 4);
                        end
                    end
                end
            end
            e0 = (rel >= 1) ? 1'(((rel < 8 ? rel : 8) - 1) % 2) : 1'b0;
            e1 = (rel >= 2) ? 1'(((rel < 11 ? rel : 11) - 2) % 2) : 1'b0;
            n_checks++;
            if (clk_div !== {2'b00, e1, e0}) begin
                n_fail++; $display("FAIL div_edge_clk_div: cycle %0d got %b want %b", rel, clk_div, {2'b00, e1, e0});
            end
            drive_idle();
            case (rel)
                0: drive_cfg(0, 0, 1'b1);
                1: drive_cfg(1, 1, 1'b1);
                6: drive_cfg(0, 0, 1'b0);
                9: drive_cfg(1, 1, 1'b0);
                default: ;
            endcase
        end
        drive_idle();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL div_edge_missing: %0d ticks not seen, want 0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        int got;
        reset_dut();
        clear_map();
        emap[4][0] = 1'b1;
        emap[8][0] = 1'b1;
        emap[5][1] = 1'b1;
        emap[6][2] = 1'b1;
        emap[7][3] = 1'b1;
        load_scoreboard(8);
        for (int rel = 0; rel <= 8; rel++) begin
            if (rel != 0) @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (tick[2'(c)]) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++; $display("FAIL arst_tick: ch%0d ticked in cycle %0d, none expected", c, rel);
                    end else begin
                        got = exp_q.pop_front();
                        if (got != rel * 4 + c) begin
                            n_fail++; $display("FAIL arst_tick: ch%0d in cycle %0d, expected ch%0d in cycle %0d", c, rel, got % 4, got / 4);
                        end
                    end
                end
            end
            drive_idle();
            if (rel <= 3) drive_cfg(rel, 4, 1'b1);
            else if (rel <= 7) drive_cfg(rel - 4, 20, 1'b1);
        end
        drive_idle();
        n_checks++;
        if ({tick, clk_div, busy} !== 12'h1FF) begin
            n_fail++; $display("FAIL arst_pre: tick/clk_div/busy got %h want 1ff", {tick, clk_div, busy});
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (tick !== 4'b0000) begin n_fail++; $display("FAIL arst_tick_clear: got %b want 0000", tick); end
        n_checks++;
        if (clk_div !== 4'b0000) begin n_fail++; $display("FAIL arst_clk_div_clear: got %b want 0000", clk_div); end
        n_checks++;
        if (busy !== 4'b0000) begin n_fail++; $display("FAIL arst_busy_clear: got %b want 0000", busy); end
        for (int c = 0; c < 4; c++) begin
            cfg_ch = 2'(c);
            #1;
            n_checks++;
            if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: ch%0d got %b want 1", c, cfg_ready); end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL arst_missing: %0d ticks not seen, want 0", exp_q.size()); end

        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        clear_map();
        emap[2][1] = 1'b1;
        emap[4][1] = 1'b1;
        load_scoreboard(5);
        for (int rel = 0; rel <= 5; rel++) begin
            if (rel != 0) @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (tick[2'(c)]) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++; $display("FAIL arst_restart_tick: ch%0d ticked in cycle %0d, none expected", c, rel);
                    end else begin
                        got = exp_q.pop_front();
                        if (got != rel * 4 + c) begin
                            n_fail++; $display("FAIL arst_restart_tick: ch%0d in cycle %0d, expected ch%0d in cycle %0d", c, rel, got % 4, got / 4);
                        end
                    end
                end
            end
            if (rel == 3) begin
                n_checks++;
                if (clk_div !== 4'b0010) begin n_fail++; $display("FAIL arst_restart_clk_div: got %b want 0010", clk_div); end
            end
            drive_idle();
            if (rel == 0) drive_cfg(1, 2, 1'b1);
        end
        drive_idle();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL arst_restart_missing: %0d ticks not seen, want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_rate_change();
        test_back_to_back();
        test_sync_restart();
        test_div_edge();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
